// File: rtl/sprite_rom_arbiter_pkg.sv
// Shared constants and types for the sprite ROM arbiter.
// OBJ_LIMIT sets the lane count; the sprite ROM geometry is fixed by the BRAM.
package sprite_rom_arbiter_pkg;

  localparam int OBJ_LIMIT     = 4;
  localparam int SPRITE_ADDR_W = 14;
  localparam int SPRITE_DATA_W = 12;
  localparam int CNT_W         = 16;

  typedef struct packed {
    logic [SPRITE_ADDR_W-1:0] addr;
  } sprite_req_t;

  // Pointer width that stays legal when there is only one lane.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sprite_rom_arbiter_picker.sv
// Rotate-priority encoder: first valid lane at or above ptr, wrapping modulo N_REQ.
// Purely combinational; ptr may be any value below N_REQ, so N_REQ need not be a power of 2.
module sprite_rr_picker
  import sprite_rom_arbiter_pkg::*;
#(
  parameter int N_REQ = OBJ_LIMIT,
  parameter int PTR_W = ptr_width(N_REQ)
) (
  input  logic [N_REQ-1:0] valid_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [PTR_W-1:0] idx_o,
  output logic             any_o
);

  int               cand;
  logic [PTR_W-1:0] cidx;

  // Scan from farthest to nearest so the lane closest to ptr is the last writer.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    cand    = 0;
    cidx    = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = (int'(ptr_i) + k) % N_REQ;
      cidx = cand[PTR_W-1:0];
      if (valid_i[cidx]) begin
        grant_o       = '0;
        grant_o[cidx] = 1'b1;
        idx_o         = cidx;
        any_o         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous sprite ROM port among N_REQ render lanes.
// Define SPRITE_ARB_STATS_EN to add the saturating per-lane grant counters (grant_cnt_o).
module sprite_rom_arbiter
  import sprite_rom_arbiter_pkg::*;
#(
  parameter int N_REQ   = OBJ_LIMIT,
  parameter int ADDR_W  = SPRITE_ADDR_W,
  parameter int DATA_W  = SPRITE_DATA_W,
  parameter int ROM_LAT = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    frame_start_i,
  input  logic [N_REQ-1:0]        req_valid_i,
  input  logic [N_REQ*ADDR_W-1:0] req_addr_i,
  output logic [N_REQ-1:0]        req_ready_o,
  output logic                    rom_en_o,
  output logic [ADDR_W-1:0]       rom_addr_o,
  input  logic [DATA_W-1:0]       rom_data_i,
  output logic [N_REQ-1:0]        rsp_valid_o,
  output logic [DATA_W-1:0]       rsp_data_o
`ifdef SPRITE_ARB_STATS_EN
  ,
  output logic [N_REQ*CNT_W-1:0]  grant_cnt_o
`endif
);

  localparam int               PTR_W = ptr_width(N_REQ);
  localparam logic [PTR_W-1:0] LAST  = PTR_W'(N_REQ - 1);

  // Handshake: lane i transfers in a cycle where req_valid_i[i] && req_ready_o[i].
  // ready is a function of all valids and ptr only, never of its own ready.
  // Responses have no backpressure; rsp_valid_o must be accepted when it appears.
  logic [N_REQ-1:0]  grant_oh;
  logic [PTR_W-1:0]  grant_idx;
  logic              xfer;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic              rom_en_q;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [N_REQ-1:0]  tag_q [ROM_LAT+1];
  logic [N_REQ-1:0]  rsp_valid_q;
  logic [DATA_W-1:0] rsp_data_q;

  sprite_rr_picker #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_picker (
    .valid_i (req_valid_i),
    .ptr_i   (ptr_q),
    .grant_o (grant_oh),
    .idx_o   (grant_idx),
    .any_o   (xfer)
  );

  assign req_ready_o = grant_oh;

  // A frame boundary restarts the rotation even if a grant happens in the same cycle.
  always_comb begin
    ptr_d      = ptr_q;
    rom_addr_d = rom_addr_q;
    if (frame_start_i) begin
      ptr_d = '0;
    end else if (xfer) begin
      ptr_d = (grant_idx == LAST) ? '0 : grant_idx + 1'b1;
    end
    if (xfer) begin
      rom_addr_d = req_addr_i[grant_idx*ADDR_W +: ADDR_W];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q       <= '0;
      rom_en_q    <= 1'b0;
      rom_addr_q  <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      for (int k = 0; k <= ROM_LAT; k++) tag_q[k] <= '0;
    end else begin
      ptr_q       <= ptr_d;
      rom_en_q    <= xfer;
      rom_addr_q  <= rom_addr_d;
      tag_q[0]    <= grant_oh;
      for (int k = 1; k <= ROM_LAT; k++) tag_q[k] <= tag_q[k-1];
      rsp_valid_q <= tag_q[ROM_LAT];
      rsp_data_q  <= rom_data_i;
    end
  end

  assign rom_en_o    = rom_en_q;
  assign rom_addr_o  = rom_addr_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;

`ifdef SPRITE_ARB_STATS_EN
  logic [CNT_W-1:0] cnt_q [N_REQ];
  logic [CNT_W-1:0] cnt_d [N_REQ];

  // Clearing on frame_start wins over a same-cycle increment; counters stick at all-ones.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (frame_start_i) begin
        cnt_d[i] = '0;
      end else if (grant_oh[i] && (cnt_q[i] != '1)) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < N_REQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cnt_out
    assign grant_cnt_o[gi*CNT_W +: CNT_W] = cnt_q[gi];
  end
`endif

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter: grant vectors from a table, responses through an expected queue.
// Builds with or without SPRITE_ARB_STATS_EN; the counter checks run only when it is defined.
module tb_sprite_rom_arbiter;
  import sprite_rom_arbiter_pkg::*;

  localparam int W = 48;  // {due cycle[47:16], lane one-hot[15:12], data[11:0]}

  logic        clk = 1'b0;
  logic        rst;
  logic        fs;
  logic [3:0]  req_valid;
  logic [55:0] req_addr;
  logic [3:0]  req_ready;
  logic        rom_en;
  logic [13:0] rom_addr;
  logic [11:0] rom_data;
  logic [3:0]  rsp_valid;
  logic [11:0] rsp_data;
`ifdef SPRITE_ARB_STATS_EN
  logic [63:0] grant_cnt;
`endif

  // Clock / reset
  always #5 clk = ~clk;

  sprite_rom_arbiter #(
    .N_REQ   (4),
    .ADDR_W  (14),
    .DATA_W  (12),
    .ROM_LAT (2)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .frame_start_i (fs),
    .req_valid_i   (req_valid),
    .req_addr_i    (req_addr),
    .req_ready_o   (req_ready),
    .rom_en_o      (rom_en),
    .rom_addr_o    (rom_addr),
    .rom_data_i    (rom_data),
    .rsp_valid_o   (rsp_valid),
    .rsp_data_o    (rsp_data)
`ifdef SPRITE_ARB_STATS_EN
    ,
    .grant_cnt_o   (grant_cnt)
`endif
  );

  // ROM model, latency 2: word = addr[11:0]
  logic [11:0] rom_p0 = '0;
  logic [11:0] rom_p1 = '0;
  always @(posedge clk) begin
    if (rom_en) rom_p0 <= rom_addr[11:0];
    rom_p1 <= rom_p0;
  end
  assign rom_data = rom_p1;

  // Scoreboard
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc      = 0;
  logic [W-1:0] exp_q[$];
  logic [13:0] last_addr;
  sprite_req_t lane_req [4];

  typedef struct {
    logic [3:0] valid;
    logic       fs;
    logic [3:0] exp_ready;
  } vec_t;
  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // One clock: advance, then check the response port against the queue head.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (exp_q.size() > 0 && exp_q[0][47:16] == 32'(cyc)) begin
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_q[0][15:12]));
      chk("rsp_data", 32'(rsp_data), 32'(exp_q[0][11:0]));
      void'(exp_q.pop_front());
    end else begin
      chk("rsp_idle", 32'(rsp_valid), 32'd0);
    end
  endtask

  // Driver: apply one request cycle and check grant, ROM port and enqueue the response.
  task automatic cycle(input logic [3:0] v, input logic f, input logic [3:0] e);
    int lane;
    req_valid = v;
    fs        = f;
    #1;
    chk("req_ready", 32'(req_ready), 32'(e));
    tick();
    fs = 1'b0;
    chk("rom_en", 32'(rom_en), 32'(e != 4'd0));
    if (e != 4'd0) begin
      lane = 0;
      for (int i = 0; i < 4; i++) if (e[i]) lane = i;
      last_addr = lane_req[lane].addr;
      exp_q.push_back({32'(cyc + 3), e, lane_req[lane].addr[11:0]});
    end
    chk("rom_addr", 32'(rom_addr), 32'(last_addr));
  endtask

  task automatic add(input logic [3:0] v, input logic f, input logic [3:0] e);
    vec_t t;
    t.valid = v;
    t.fs = f;
    t.exp_ready = e;
    vq.push_back(t);
  endtask

  initial begin
    lane_req[0].addr = 14'h20A0;
    lane_req[1].addr = 14'h11B1;
    lane_req[2].addr = 14'h0123;
    lane_req[3].addr = 14'h33D3;
    for (int i = 0; i < 4; i++) req_addr[i*14 +: 14] = lane_req[i].addr;
    rst = 1'b1;
    fs = 1'b0;
    req_valid = '0;
    last_addr = '0;

    // Vector table, ptr=0 after reset
    add(4'b0100, 1'b0, 4'b0100);                     // lane 2 alone, ptr -> 3
    repeat (5) add(4'b0000, 1'b0, 4'b0000);
    add(4'b0000, 1'b1, 4'b0000);                     // ptr -> 0
    for (int k = 0; k < 8; k++) add(4'b1111, 1'b0, 4'(1 << (k % 4)));
    add(4'b1010, 1'b0, 4'b0010);                     // ptr -> 2
    add(4'b1010, 1'b1, 4'b1000);                     // old ptr used, ptr -> 0
    add(4'b1010, 1'b0, 4'b0010);                     // ptr -> 2
    add(4'b0010, 1'b1, 4'b0010);                     // wrap search, frame_start forces ptr 0
    add(4'b1010, 1'b0, 4'b0010);                     // lane 1 again proves the override
    add(4'b0011, 1'b0, 4'b0001);                     // from 2 wraps to 0, ptr -> 1
    add(4'b0011, 1'b0, 4'b0010);                     // ptr -> 2
    add(4'b1001, 1'b0, 4'b1000);                     // ptr -> 0
    add(4'b0110, 1'b0, 4'b0010);                     // ptr -> 2
    add(4'b0101, 1'b0, 4'b0100);                     // ptr -> 3
    add(4'b0101, 1'b0, 4'b0001);                     // ptr -> 1
    repeat (6) add(4'b0000, 1'b0, 4'b0000);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rom_en", 32'(rom_en), 32'd0);
    chk("reset_rom_addr", 32'(rom_addr), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_data", 32'(rsp_data), 32'd0);
    chk("reset_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;

    repeat (10) cycle(4'b0000, 1'b0, 4'b0000);

    foreach (vq[i]) cycle(vq[i].valid, vq[i].fs, vq[i].exp_ready);

    // Reset one cycle after a lane-0 transfer drops that read; ptr restarts at 0
    cycle(4'b0001, 1'b0, 4'b0001);
    cycle(4'b0000, 1'b0, 4'b0000);
    rst = 1'b1;
    #1;
    exp_q.delete();
    last_addr = '0;
    chk("midrst_rom_en", 32'(rom_en), 32'd0);
    chk("midrst_rom_addr", 32'(rom_addr), 32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    repeat (6) cycle(4'b0000, 1'b0, 4'b0000);
    cycle(4'b1111, 1'b0, 4'b0001);
    repeat (6) cycle(4'b0000, 1'b0, 4'b0000);

`ifdef SPRITE_ARB_STATS_EN
    cycle(4'b0000, 1'b1, 4'b0000);
    chk("cnt_clear", 32'(grant_cnt), 32'd0);
    repeat (3) cycle(4'b0001, 1'b0, 4'b0001);
    chk("cnt0_three", 32'(grant_cnt[15:0]), 32'd3);
    cycle(4'b0001, 1'b1, 4'b0001);
    chk("cnt0_clear_priority", 32'(grant_cnt[15:0]), 32'd0);
    repeat (6) cycle(4'b0000, 1'b0, 4'b0000);
    req_valid = 4'b0001;
    repeat (70000) @(posedge clk);
    #1;
    req_valid = 4'b0000;
    repeat (8) @(posedge clk);
    #1;
    chk("cnt0_saturated", 32'(grant_cnt[15:0]), 32'hFFFF);
    chk("cnt_others_zero", 32'(grant_cnt[63:16]), 32'd0);
    fs = 1'b1;
    @(posedge clk);
    #1;
    fs = 1'b0;
    chk("cnt_frame_clear", 32'(grant_cnt[15:0]), 32'd0);
`endif

    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
